ysyx_regfile_mp: RTL and testbench
==================================

# ysyx_regfile_mp

Parametrised multi-port integer register file for the NPC core, replacing the single-write/dual-read file in the decode/writeback path. Adds configurable width, depth and port counts, a hardwired zero register, write-to-read bypass, deterministic write-conflict priority, and a hardware clear sequencer. Writes are reported on a registered commit-trace port instead of simulation prints, so the difftest harness can capture them.

## Interface
- `XLEN`, default 32: data width.
- `NREG`, default 32: number of registers. Must be a power of two, ≥2. `AW = $clog2(NREG)`.
- `NRD`, default 2: read ports.
- `NWR`, default 2: write ports. A higher index has higher priority.
- `BYPASS`, default 1: forward same-cycle write data to reads.
- `ZERO_REG`, default 1: register 0 reads 0 and ignores writes.

Ports:
- `clk`  in  1: the single clock. All state changes on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `wr_en`  in  NWR: per-port write enable.
- `waddr`  in  NWR*AW: write addresses, packed; port i at `[i*AW +: AW]`.
- `wdata`  in  NWR*XLEN: write data, packed likewise.
- `raddr`  in  NRD*AW: read addresses, packed.
- `rdata`  out  NRD*XLEN: read data, combinational.
- `clr_req`  in  1: one-cycle pulse requesting a full clear.
- `busy`  out  1: clear in progress. While high, writes are ignored and reads return 0.
- `trace_valid`  out  NWR: per-port commit strobe, registered.
- `trace_addr`  out  NWR*AW: committed address.
- `trace_old`  out  NWR*XLEN: register value before the commit.
- `trace_new`  out  NWR*XLEN: value written.

## Operation
- **Clear FSM states:** CLEAR and IDLE.
  - While `rst_n`=0: state ← CLEAR, `clr_cnt` ← 0.
  - In CLEAR: `rf[clr_cnt]` ← 0 and `clr_cnt` increments each cycle. When `clr_cnt` = NREG-1, the FSM moves to IDLE after that write.
  - In IDLE: `clr_req`=1 moves the FSM to CLEAR with `clr_cnt` ← 0.
  - `clr_req` during CLEAR is ignored; it does not restart the count.
  - Reset during CLEAR restarts the count at 0.
- `busy` = (state == CLEAR). Reset value is 1.
- **Effective write:** port i commits when all of the following hold:
  - `wr_en[i]` is set and `busy`=0;
  - the address is not 0 when ZERO_REG=1;
  - no port j>i has an effective-candidate write to the same address.
- Only effective writes update the array and the trace.
- **Read, port k:**
  - If `busy`, the result is 0.
  - If ZERO_REG and `raddr`=0, the result is 0.
  - If BYPASS and any effective write targets `raddr`, the result is the `wdata` of the highest such port.
  - Otherwise the result is `rf[raddr]`.
- **Trace:**
  - Port i's trace fields register on the edge where its write commits. They are held until the next commit.
  - `trace_valid[i]` is high for exactly one cycle per effective write.
  - `trace_old` is the array value before the edge, not the bypassed value.
  - Writes dropped by priority or by the zero-register rule produce no trace.
- **Reset values:**
  - `trace_valid` = 0; `trace_addr`, `trace_old`, `trace_new` = 0.
  - Array contents are defined only after the clear completes.

## Timing
- Read latency is 0 cycles (combinational from `raddr`, `wr_en`, `waddr`, `wdata` and state).
- Write latency: visible from the array on the cycle after the edge, or in the same cycle through the bypass.
- Trace latency: 1 cycle after the `wr_en` cycle.
- Clear takes exactly NREG cycles from the first cycle with `rst_n`=1, or from the cycle after `clr_req` is sampled. `busy` falls on the edge that completes the last clear write.
- Simultaneous `clr_req` and `wr_en` in IDLE: the write commits and is traced, and the clear starts on the next cycle.

## Structure
- **Package `ysyx_rf_pkg`:** state enum `rf_state_e {RF_IDLE, RF_CLEAR}` and the default parameter constants (`RF_XLEN`, `RF_NREG`).
- **Sub-module `ysyx_rf_clear_fsm`:**
  - Inputs: `clk`, `rst_n`, `clr_req`.
  - Outputs: `busy`, `clr_we`, `clr_addr`.
  - Port priority, bypass and trace logic stay in the top module.

## Test plan
- **Reset clear:** assert `rst_n`=0 for 2 cycles, then release. Required: `busy`=1 for exactly 32 cycles, then 0. Afterwards all reads return 0 and `trace_valid`=0 throughout.
- **Basic write/read:** write port 0, addr 5, data 0xDEADBEEF. Required:
  - next cycle, `rdata[0]` at raddr 5 = 0xDEADBEEF;
  - `trace_valid[0]`=1 with addr 5, old 0, new 0xDEADBEEF.
- **Conflict:** port 0 and port 1 both write addr 7, with 0x11 and 0x22. Required: `rf[7]`=0x22, `trace_valid`=2'b10, and the same-cycle bypass read of 7 returns 0x22.
- **Zero register:** write addr 0 with 0xFFFFFFFF. Required: reads of addr 0 return 0 in the same and the next cycle, and there is no trace.
- **Bypass:** read addr 9 (holding 0xA) while port 1 writes 0xB to 9. Required: same-cycle `rdata` = 0xB. With BYPASS=0 the same-cycle read returns 0xA and the next cycle returns 0xB.
- **Runtime clear and blocked writes:**
  - Pulse `clr_req` in IDLE. A write issued 3 cycles later is dropped: no trace, and the register stays 0 after the clear.
  - A second `clr_req` mid-clear does not extend `busy` beyond 32 cycles.
  - `rst_n` low mid-clear restarts a full 32-cycle clear.

Source files
------------

// File: rtl/ysyx_regfile_mp_pkg.sv
// Shared types and default sizing for the
// multi-port integer register file.
package ysyx_rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_XLEN = 32;
  localparam int RF_NREG = 32;
  localparam int RF_NRD  = 2;
  localparam int RF_NWR  = 2;

endpackage

// File: rtl/ysyx_regfile_mp_if.sv
// Bus bundle of the register file: write/read
// ports, clear request/busy and commit trace.
interface ysyx_regfile_mp_if
  import ysyx_rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int NREG = RF_NREG,
  parameter int NRD  = RF_NRD,
  parameter int NWR  = RF_NWR
);
  localparam int AW = $clog2(NREG);

  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic                clr_req;
  logic                busy;
  logic [NWR-1:0]      trace_valid;
  logic [NWR*AW-1:0]   trace_addr;
  logic [NWR*XLEN-1:0] trace_old;
  logic [NWR*XLEN-1:0] trace_new;

  modport master (
    output wr_en,
    output waddr,
    output wdata,
    output raddr,
    output clr_req,
    input  rdata,
    input  busy,
    input  trace_valid,
    input  trace_addr,
    input  trace_old,
    input  trace_new
  );

  modport slave (
    input  wr_en,
    input  waddr,
    input  wdata,
    input  raddr,
    input  clr_req,
    output rdata,
    output busy,
    output trace_valid,
    output trace_addr,
    output trace_old,
    output trace_new
  );

endinterface

// File: rtl/ysyx_regfile_mp_clear_fsm.sv
// Clear sequencer: walks every register once
// after reset or on a clear request.
module ysyx_rf_clear_fsm
  import ysyx_rf_pkg::*;
#(
  parameter int NREG = RF_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // requests during a clear are ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      RF_IDLE: begin
        if (clr_req) state_d = RF_CLEAR;
      end
      RF_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1))
          state_d = RF_IDLE;
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  always_comb begin
    busy     = (state_q == RF_CLEAR);
    clr_we   = (state_q == RF_CLEAR);
    clr_addr = cnt_q;
  end

endmodule

// File: rtl/ysyx_regfile_mp.sv
// Multi-port register file with zero register,
// write bypass, port priority and commit trace.
module ysyx_regfile_mp
  import ysyx_rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREG     = RF_NREG,
  parameter int NRD      = RF_NRD,
  parameter int NWR      = RF_NWR,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic             clk,
  input logic             rst_n,
  ysyx_regfile_mp_if.slave bus
);

  localparam int AW  = $clog2(NREG);
  localparam bit ZR  = (ZERO_REG != 0);
  localparam bit BYP = (BYPASS != 0);

  logic [NWR-1:0][AW-1:0]   wa;
  logic [NWR-1:0][XLEN-1:0] wd;
  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0][XLEN-1:0] rd;

  assign wa = bus.waddr;
  assign wd = bus.wdata;
  assign ra = bus.raddr;

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  ysyx_rf_clear_fsm #(
    .NREG (NREG),
    .AW   (AW)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;

  logic [NWR-1:0] cand;
  logic [NWR-1:0] eff;

  // a higher port to the same address wins
  always_comb begin
    cand = '0;
    eff  = '0;
    for (int i = 0; i < NWR; i++) begin
      cand[i] = bus.wr_en[i] & ~busy &
                ~(ZR && (wa[i] == '0));
    end
    for (int i = 0; i < NWR; i++) begin
      eff[i] = cand[i];
      for (int j = i + 1; j < NWR; j++) begin
        if (cand[j] && (wa[j] == wa[i]))
          eff[i] = 1'b0;
      end
    end
  end

  logic [XLEN-1:0] rf_q [NREG];

  always_ff @(posedge clk) begin
    if (clr_we) rf_q[clr_addr] <= '0;
    for (int i = 0; i < NWR; i++) begin
      if (eff[i]) rf_q[wa[i]] <= wd[i];
    end
  end

  always_comb begin
    rd = '0;
    for (int k = 0; k < NRD; k++) begin
      rd[k] = rf_q[ra[k]];
      if (BYP) begin
        for (int i = 0; i < NWR; i++) begin
          if (eff[i] && (wa[i] == ra[k]))
            rd[k] = wd[i];
        end
      end
      if (ZR && (ra[k] == '0)) rd[k] = '0;
      if (busy) rd[k] = '0;
    end
  end

  assign bus.rdata = rd;

  logic [NWR-1:0]           tv_q, tv_d;
  logic [NWR-1:0][AW-1:0]   ta_q, ta_d;
  logic [NWR-1:0][XLEN-1:0] to_q, to_d;
  logic [NWR-1:0][XLEN-1:0] tn_q, tn_d;

  // old value comes from the array, not bypass
  always_comb begin
    tv_d = eff;
    ta_d = ta_q;
    to_d = to_q;
    tn_d = tn_q;
    for (int i = 0; i < NWR; i++) begin
      if (eff[i]) begin
        ta_d[i] = wa[i];
        to_d[i] = rf_q[wa[i]];
        tn_d[i] = wd[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tv_q <= '0;
      ta_q <= '0;
      to_q <= '0;
      tn_q <= '0;
    end else begin
      tv_q <= tv_d;
      ta_q <= ta_d;
      to_q <= to_d;
      tn_q <= tn_d;
    end
  end

  assign bus.trace_valid = tv_q;
  assign bus.trace_addr  = ta_q;
  assign bus.trace_old   = to_q;
  assign bus.trace_new   = tn_q;

endmodule

// File: tb/tb_ysyx_regfile_mp.sv
// Scoreboard bench: directed plus random traffic
// against a spec-level register file model.
module tb_ysyx_regfile_mp;
  import ysyx_rf_pkg::*;

  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_regfile_mp_if #(
    .XLEN(32), .NREG(NREG), .NRD(2), .NWR(2)
  ) bif ();
  ysyx_regfile_mp_if #(
    .XLEN(32), .NREG(NREG), .NRD(2), .NWR(2)
  ) nif ();

  assign nif.wr_en   = bif.wr_en;
  assign nif.waddr   = bif.waddr;
  assign nif.wdata   = bif.wdata;
  assign nif.raddr   = bif.raddr;
  assign nif.clr_req = bif.clr_req;

  ysyx_regfile_mp #(
    .XLEN(32), .NREG(NREG), .NRD(2), .NWR(2),
    .BYPASS(1), .ZERO_REG(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  ysyx_regfile_mp #(
    .XLEN(32), .NREG(NREG), .NRD(2), .NWR(2),
    .BYPASS(0), .ZERO_REG(1)
  ) u_nbyp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (nif)
  );

  typedef struct packed {
    logic             busy;
    logic [1:0][31:0] r;
    logic [1:0][31:0] n;
  } exp_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] o;
    logic [31:0] v;
  } tr_t;

  exp_t eq[$];
  tr_t  tq0[$];
  tr_t  tq1[$];

  logic [31:0] mem [NREG];
  int clr_left = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h",
               nm, act, exp);
    end
  endtask

  exp_t me;
  tr_t  mt;

  always @(negedge clk) begin
    if (eq.size() > 0) begin
      me = eq.pop_front();
      chk("busy", {31'd0, bif.busy},
          {31'd0, me.busy});
      chk("rdata0", bif.rdata[31:0], me.r[0]);
      chk("rdata1", bif.rdata[63:32], me.r[1]);
      chk("nb_busy", {31'd0, nif.busy},
          {31'd0, me.busy});
      chk("nb_rdata0", nif.rdata[31:0], me.n[0]);
      chk("nb_rdata1", nif.rdata[63:32], me.n[1]);
    end
    if (bif.trace_valid[0]) begin
      if (tq0.size() == 0) begin
        chk("trace_valid0", 32'd1, 32'd0);
      end else begin
        mt = tq0.pop_front();
        chk("trace_addr0",
            {27'd0, bif.trace_addr[4:0]},
            {27'd0, mt.a});
        chk("trace_old0", bif.trace_old[31:0], mt.o);
        chk("trace_new0", bif.trace_new[31:0], mt.v);
      end
    end
    if (bif.trace_valid[1]) begin
      if (tq1.size() == 0) begin
        chk("trace_valid1", 32'd1, 32'd0);
      end else begin
        mt = tq1.pop_front();
        chk("trace_addr1",
            {27'd0, bif.trace_addr[9:5]},
            {27'd0, mt.a});
        chk("trace_old1", bif.trace_old[63:32], mt.o);
        chk("trace_new1", bif.trace_new[63:32], mt.v);
      end
    end
  end

  task automatic step(input logic [1:0]  we,
                      input logic [4:0]  a0,
                      input logic [4:0]  a1,
                      input logic [31:0] d0,
                      input logic [31:0] d1,
                      input logic [4:0]  r0,
                      input logic [4:0]  r1,
                      input logic        clr);
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [4:0]  ra [2];
    logic        cand [2];
    logic        eff [2];
    logic        bsy;
    logic [31:0] v, nv;
    exp_t        e;
    tr_t         t;
    wa[0] = a0; wa[1] = a1;
    wd[0] = d0; wd[1] = d1;
    ra[0] = r0; ra[1] = r1;
    bif.wr_en   = we;
    bif.waddr   = {a1, a0};
    bif.wdata   = {d1, d0};
    bif.raddr   = {r1, r0};
    bif.clr_req = clr;
    bsy = (clr_left != 0);
    for (int i = 0; i < 2; i++)
      cand[i] = we[i] && !bsy && (wa[i] != 0);
    for (int i = 0; i < 2; i++) begin
      eff[i] = cand[i];
      for (int j = i + 1; j < 2; j++)
        if (cand[j] && wa[j] == wa[i]) eff[i] = 0;
    end
    e.busy = bsy;
    for (int k = 0; k < 2; k++) begin
      v  = mem[ra[k]];
      nv = mem[ra[k]];
      for (int i = 0; i < 2; i++)
        if (eff[i] && wa[i] == ra[k]) v = wd[i];
      if (bsy || ra[k] == 0) begin
        v  = 0;
        nv = 0;
      end
      e.r[k] = v;
      e.n[k] = nv;
    end
    eq.push_back(e);
    for (int i = 0; i < 2; i++) begin
      if (eff[i]) begin
        t.a = wa[i];
        t.o = mem[wa[i]];
        t.v = wd[i];
        if (i == 0) tq0.push_back(t);
        else        tq1.push_back(t);
      end
    end
    @(posedge clk);
    if (clr_left > 0) begin
      clr_left--;
    end else begin
      for (int i = 0; i < 2; i++)
        if (eff[i]) mem[wa[i]] = wd[i];
      if (clr) begin
        clr_left = NREG;
        for (int m = 0; m < NREG; m++) mem[m] = 0;
      end
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] r0,
                      input logic [4:0] r1);
    step(2'b00, 0, 0, 0, 0, r0, r1, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bif.wr_en   = '0;
    bif.clr_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_left = NREG;
    for (int m = 0; m < NREG; m++) mem[m] = 0;
  endtask

  task automatic wait_free(output int n);
    n = 0;
    while (bif.busy === 1'b1 && n < 200) begin
      n++;
      idle(5'(n), 5'(n + 1));
    end
  endtask

  int n;
  logic [4:0] a0, a1, r0, r1;

  initial begin
    bif.wr_en   = '0;
    bif.waddr   = '0;
    bif.wdata   = '0;
    bif.raddr   = '0;
    bif.clr_req = 1'b0;
    do_reset(2);
    wait_free(n);
    chk("reset_busy_len", n, 32);
    for (int k = 0; k < 16; k++)
      idle(5'(2 * k), 5'(2 * k + 1));

    step(2'b01, 5, 0, 32'hDEADBEEF, 0, 5, 6, 0);
    idle(5, 0);
    step(2'b11, 7, 7, 32'h11, 32'h22, 7, 5, 0);
    idle(7, 7);
    step(2'b01, 0, 0, 32'hFFFFFFFF, 0, 0, 7, 0);
    idle(0, 0);
    step(2'b01, 9, 0, 32'hA, 0, 3, 4, 0);
    idle(9, 9);
    step(2'b10, 0, 9, 0, 32'hB, 9, 9, 0);
    idle(9, 9);

    step(2'b01, 12, 0, 32'h77, 0, 12, 5, 1);
    n = 0;
    while (bif.busy === 1'b1 && n < 200) begin
      n++;
      step((n == 3) ? 2'b01 : 2'b00, 12, 0,
           32'h5555, 0, 12, 9, (n == 10));
    end
    chk("clr_busy_len", n, 32);
    idle(12, 5);

    step(2'b00, 0, 0, 0, 0, 1, 2, 1);
    repeat (10) idle(3, 4);
    do_reset(2);
    wait_free(n);
    chk("midclr_reset_busy_len", n, 32);

    for (int c = 0; c < 400; c++) begin
      a0 = ($urandom_range(0, 1) != 0) ?
           5'($urandom_range(0, 7)) : 5'($urandom);
      a1 = ($urandom_range(0, 1) != 0) ?
           5'($urandom_range(0, 7)) : 5'($urandom);
      r0 = ($urandom_range(0, 1) != 0) ? a0 :
           5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 1) != 0) ? a1 :
           5'($urandom);
      step(2'($urandom), a0, a1, $urandom,
           $urandom, r0, r1,
           ($urandom_range(0, 99) == 0));
    end
    repeat (40) idle(1, 2);
    chk("trace_q0_left", tq0.size(), 0);
    chk("trace_q1_left", tq1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
